// File: rtl/spi_pkg.sv
// Shared constants for the 3-wire SPI receive path: FSM encoding,
// default word width and the idle levels of the SPI pins.
package spi_pkg;

    // Default bits per frame
    localparam int DATA_W_DEF = 8;

    // FSM state encoding, also used to decode diag_state
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // Idle pin levels loaded into the synchronizers at reset
    localparam logic STB_IDLE = 1'b1;
    localparam logic CLK_IDLE = 1'b1;
    localparam logic DIO_IDLE = 1'b0;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for one asynchronous input.
// The reset value lets each chain start at its pin's idle level.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// Device-side receiver of the 3-wire SPI link. Synchronizes the pins into
// clk, samples dio on rising dev_clk edges (LSB first) and emits one-cycle
// pulses for a complete word, an aborted frame, or extra clocks in a frame.
module spi_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dev_stb,
    input  logic                      dev_clk,
    input  logic                      dev_dio,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy,
    output logic [1:0]                diag_state,
    output logic [$clog2(DATA_W)-1:0] diag_cnt
);

    localparam int                  CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);

    logic              w_stb_s;
    logic              w_clk_s;
    logic              w_dio_s;
    logic              w_rise;
    logic [DATA_W-1:0] w_shift_next;

    logic              r_clk_q;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_frame_err;
    logic              r_overrun;
    logic              r_ovr_done;

    // Identical chains keep the relative timing of stb/clk/dio intact
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(STB_IDLE)) u_sync_stb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (dev_stb),
        .o_q   (w_stb_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(CLK_IDLE)) u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (dev_clk),
        .o_q   (w_clk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(DIO_IDLE)) u_sync_dio (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (dev_dio),
        .o_q   (w_dio_s)
    );

    // Remember the previous synchronized serial clock for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_q <= CLK_IDLE;
        end else begin
            r_clk_q <= w_clk_s;
        end
    end

    assign w_rise = w_clk_s & ~r_clk_q;

    // Shift register with the current data bit inserted at the bit position
    always_comb begin
        w_shift_next        = r_shift;
        w_shift_next[r_cnt] = w_dio_s;
    end

    // Frame FSM; stb deassertion takes priority over a coincident clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_ovr_done  <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_stb_s) begin
                        r_state    <= SHIFT;
                        r_cnt      <= '0;
                        r_shift    <= '0;
                        r_ovr_done <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_stb_s) begin
                        // Partial word is dropped; empty frames end silently
                        r_state     <= IDLE;
                        r_frame_err <= (r_cnt != '0);
                    end else if (w_rise) begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_rx_data  <= w_shift_next;
                            r_rx_valid <= 1'b1;
                            r_state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_stb_s) begin
                        r_state <= IDLE;
                    end else if (w_rise && !r_ovr_done) begin
                        // Report extra clocks only once per frame
                        r_overrun  <= 1'b1;
                        r_ovr_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);
    assign diag_state = r_state;
    assign diag_cnt   = r_cnt;

endmodule

// File: tb/tb_spi_rx.sv
// Directed and randomized bench for spi_rx: a transmitter model drives the
// pins, expected bytes go into a queue and are popped on each rx_valid.
`timescale 1ns/1ps
module tb_spi_rx;

    logic       clk;
    logic       rst_n;
    logic       dev_stb;
    logic       dev_clk;
    logic       dev_dio;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [1:0] diag_state;
    logic [2:0] diag_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_vld  = 0;
    int n_ferr = 0;
    int n_ovr  = 0;

    logic [7:0] exp_q[$];

    localparam int N_RAND = 500;

    spi_rx #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dev_stb    (dev_stb),
        .dev_clk    (dev_clk),
        .dev_dio    (dev_dio),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy),
        .diag_state (diag_state),
        .diag_cnt   (diag_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid || frame_err || overrun)
                chk("pulse_excl", 32'(rx_valid) + 32'(frame_err) + 32'(overrun), 32'd1);
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
            if (rx_valid) begin
                n_vld++;
                if (exp_q.size() == 0) begin
                    chk("rx_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e));
                end
            end
        end
    end

    // Half-period of the serial clock in ns for a given transmitter CYCLES
    function automatic int half_ns(input int cyc);
        return (cyc + 1) * 10;
    endfunction

    task automatic stb_low(input int cyc);
        dev_stb = 1'b0;
        #(half_ns(cyc));
    endtask

    task automatic stb_high(input int cyc);
        dev_stb = 1'b1;
        #(half_ns(cyc));
    endtask

    task automatic clock_bits(input logic [15:0] bits, input int n, input int cyc);
        for (int i = 0; i < n; i++) begin
            dev_clk = 1'b0;
            dev_dio = bits[i];
            #(half_ns(cyc));
            dev_clk = 1'b1;
            #(half_ns(cyc));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int cyc);
        exp_q.push_back(b);
        stb_low(cyc);
        clock_bits({8'h00, b}, 8, cyc);
        stb_high(cyc);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int v0, f0, o0;
        int cyc;
        logic [7:0] b;

        rst_n   = 1'b0;
        dev_stb = 1'b1;
        dev_clk = 1'b1;
        dev_dio = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rx_data",   32'(rx_data),    32'h0);
        chk("rst_rx_valid",  32'(rx_valid),   32'h0);
        chk("rst_frame_err", 32'(frame_err),  32'h0);
        chk("rst_overrun",   32'(overrun),    32'h0);
        chk("rst_busy",      32'(busy),       32'h0);
        chk("rst_state",     32'(diag_state), 32'h0);
        chk("rst_cnt",       32'(diag_cnt),   32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte A5
        v0 = n_vld; f0 = n_ferr; o0 = n_ovr;
        send_byte(8'hA5, 1);
        settle();
        chk("a5_valid_cnt", 32'(n_vld - v0),  32'd1);
        chk("a5_ferr_cnt",  32'(n_ferr - f0), 32'd0);
        chk("a5_ovr_cnt",   32'(n_ovr - o0),  32'd0);
        chk("a5_rx_data",   32'(rx_data),     32'hA5);
        chk("a5_busy",      32'(busy),        32'd0);

        // Back-to-back 01, 80, FF
        v0 = n_vld;
        send_byte(8'h01, 1);
        send_byte(8'h80, 1);
        send_byte(8'hFF, 1);
        settle();
        chk("b2b_valid_cnt", 32'(n_vld - v0),     32'd3);
        chk("b2b_q_empty",   32'(exp_q.size()),   32'd0);
        chk("b2b_rx_data",   32'(rx_data),        32'hFF);

        // Aborted frame: 5 clocks then stb high
        v0 = n_vld; f0 = n_ferr;
        stb_low(1);
        repeat (5) @(negedge clk);
        chk("ab_busy",  32'(busy),       32'd1);
        chk("ab_state", 32'(diag_state), 32'd1);
        clock_bits(16'h0015, 5, 1);
        stb_high(1);
        settle();
        chk("ab_ferr_cnt",  32'(n_ferr - f0), 32'd1);
        chk("ab_valid_cnt", 32'(n_vld - v0),  32'd0);
        chk("ab_rx_data",   32'(rx_data),     32'hFF);
        chk("ab_state_idle", 32'(diag_state), 32'd0);

        // Overlong frame: 10 clocks, first byte 3C
        v0 = n_vld; f0 = n_ferr; o0 = n_ovr;
        exp_q.push_back(8'h3C);
        stb_low(1);
        clock_bits({6'd0, 2'b11, 8'h3C}, 10, 1);
        repeat (6) @(negedge clk);
        chk("ov_state_hold", 32'(diag_state), 32'd2);
        chk("ov_busy",       32'(busy),       32'd1);
        stb_high(1);
        settle();
        chk("ov_valid_cnt", 32'(n_vld - v0),  32'd1);
        chk("ov_ovr_cnt",   32'(n_ovr - o0),  32'd1);
        chk("ov_ferr_cnt",  32'(n_ferr - f0), 32'd0);
        chk("ov_rx_data",   32'(rx_data),     32'h3C);
        chk("ov_state_idle", 32'(diag_state), 32'd0);

        // Reset in the middle of frame 5A, then C3
        v0 = n_vld; f0 = n_ferr; o0 = n_ovr;
        stb_low(1);
        clock_bits(16'h005A, 4, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_rx_data",  32'(rx_data),  32'h0);
        chk("mr_busy",     32'(busy),     32'd0);
        chk("mr_pulses",   32'({rx_valid, frame_err, overrun}), 32'd0);
        dev_stb = 1'b1;
        dev_clk = 1'b1;
        dev_dio = 1'b0;
        repeat (4) @(negedge clk);
        chk("mr_pulses_hold", 32'({rx_valid, frame_err, overrun}), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mr_rx_data_after", 32'(rx_data),     32'h0);
        chk("mr_state_after",   32'(diag_state),  32'd0);
        send_byte(8'hC3, 1);
        settle();
        chk("mr_valid_cnt", 32'(n_vld - v0),  32'd1);
        chk("mr_ferr_cnt",  32'(n_ferr - f0), 32'd0);
        chk("mr_ovr_cnt",   32'(n_ovr - o0),  32'd0);
        chk("mr_rx_data_c3", 32'(rx_data),    32'hC3);

        // Random bytes at random phase and CYCLES 1..4
        v0 = n_vld; f0 = n_ferr; o0 = n_ovr;
        for (int k = 0; k < N_RAND; k++) begin
            cyc = int'($urandom_range(1, 4));
            b   = 8'($urandom_range(0, 255));
            #($urandom_range(1, 9));
            send_byte(b, cyc);
        end
        settle();
        chk("rnd_valid_cnt", 32'(n_vld - v0),   32'(N_RAND));
        chk("rnd_ferr_cnt",  32'(n_ferr - f0),  32'd0);
        chk("rnd_ovr_cnt",   32'(n_ovr - o0),   32'd0);
        chk("rnd_q_empty",   32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
